// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU-to-memory bus arbiter.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } arbState_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [2:0] KSEG0 = 3'b100;
  localparam logic [2:0] KSEG1 = 3'b101;

  function automatic logic isUnmappedSeg(input logic [31:0] vaddr);
    return (vaddr[31:29] == KSEG0) || (vaddr[31:29] == KSEG1);
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter_addr_map.sv
// Virtual-to-physical translation: kseg0/kseg1 drop the top three bits.
module addr_map
  import cpu_bus_pkg::*;
(
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

  assign paddr = isUnmappedSeg(vaddr) ? {3'b000, vaddr[28:0]} : vaddr;

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-outstanding bus.
// state | meaning: S_IDLE no transaction | S_REQ request held until addr_ok | S_WAIT awaiting data_ok
module cpu_mem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_stall,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  input  logic        pipe_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arbState_e   state, stateNext;
  owner_e      owner, ownerNext;
  logic        instDone, instDoneNext;
  logic        dataDone, dataDoneNext;
  logic        discard, discardNext;
  logic        memReqNext, memWrNext;
  logic [3:0]  memWstrbNext;
  logic [31:0] memAddrNext, memWdataNext;
  logic [31:0] instRdataNext, dataRdataNext;
  logic [31:0] instPhys, dataPhys;
  logic        instPend, dataPend, selData, advance, killInst;

  addr_map uInstMap (.vaddr(inst_addr), .paddr(instPhys));
  addr_map uDataMap (.vaddr(data_addr), .paddr(dataPhys));

  assign instPend   = inst_en & ~instDone;
  assign dataPend   = data_en & ~dataDone;
  assign inst_stall = instPend;
  assign data_stall = dataPend;
  assign selData    = dataPend & (DATA_PRIO | ~instPend);
  assign advance    = ~instPend & ~dataPend & ~pipe_stall;
  assign killInst   = flush & (owner == OWN_INST);

  always_comb begin
    stateNext     = state;
    ownerNext     = owner;
    instDoneNext  = instDone;
    dataDoneNext  = dataDone;
    discardNext   = discard;
    memReqNext    = mem_req;
    memWrNext     = mem_wr;
    memWstrbNext  = mem_wstrb;
    memAddrNext   = mem_addr;
    memWdataNext  = mem_wdata;
    instRdataNext = inst_rdata;
    dataRdataNext = data_rdata;

    if (flush || advance) begin
      instDoneNext = 1'b0;
      dataDoneNext = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (selData) begin
          stateNext    = S_REQ;
          ownerNext    = OWN_DATA;
          memReqNext   = 1'b1;
          memWrNext    = |data_wen;
          memWstrbNext = data_wen;
          memAddrNext  = dataPhys;
          memWdataNext = data_wdata;
        end else if (instPend) begin
          stateNext    = S_REQ;
          ownerNext    = OWN_INST;
          memReqNext   = 1'b1;
          memWrNext    = 1'b0;
          memWstrbNext = 4'b0000;
          memAddrNext  = instPhys;
          memWdataNext = 32'h0;
        end
      end
      S_REQ: begin
        // A flush before acceptance leaves the held request untouched.
        if (mem_addr_ok) begin
          stateNext  = S_WAIT;
          memReqNext = 1'b0;
          if (killInst) discardNext = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_data_ok) begin
          stateNext   = S_IDLE;
          discardNext = 1'b0;
          if (!(discard || killInst)) begin
            if (owner == OWN_INST) begin
              instDoneNext  = 1'b1;
              instRdataNext = mem_rdata;
            end else begin
              dataDoneNext = 1'b1;
              if (!mem_wr) dataRdataNext = mem_rdata;
            end
          end
        end else if (killInst) begin
          discardNext = 1'b1;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_INST;
      instDone   <= 1'b0;
      dataDone   <= 1'b0;
      discard    <= 1'b0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wstrb  <= 4'b0000;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      inst_rdata <= 32'h0;
      data_rdata <= 32'h0;
    end else begin
      state      <= stateNext;
      owner      <= ownerNext;
      instDone   <= instDoneNext;
      dataDone   <= dataDoneNext;
      discard    <= discardNext;
      mem_req    <= memReqNext;
      mem_wr     <= memWrNext;
      mem_wstrb  <= memWstrbNext;
      mem_addr   <= memAddrNext;
      mem_wdata  <= memWdataNext;
      inst_rdata <= instRdataNext;
      data_rdata <= dataRdataNext;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed scenarios plus randomized request pairs against a transaction-level bus model.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_en = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic [31:0] inst_rdata;
  logic        inst_stall;
  logic        data_en = 1'b0;
  logic [3:0]  data_wen = 4'h0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic [31:0] data_rdata;
  logic        data_stall;
  logic        pipe_stall = 1'b0;
  logic        flush = 1'b0;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  cpu_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_stall(inst_stall),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_stall(data_stall),
    .pipe_stall(pipe_stall), .flush(flush),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } busTxn_t;

  busTxn_t     busLog[$];
  int          checks = 0;
  int          errors = 0;
  int          addrLat = 0;
  int          dataLat = 0;
  bit          useFixed = 1'b0;
  logic [31:0] fixedRdata = 32'h0;
  bit          respWait = 1'b0;
  int          respCnt = 0;
  logic [31:0] respAddr = 32'h0;

  function automatic logic [31:0] physOf(input logic [31:0] v);
    if (v >= 32'h8000_0000 && v < 32'hC000_0000) return v & 32'h1FFF_FFFF;
    return v;
  endfunction

  function automatic logic [31:0] busWord(input logic [31:0] p);
    return {p[15:0], p[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] randAddr();
    logic [31:0] r;
    r = $urandom;
    r[1:0] = 2'b00;
    return r;
  endfunction

  // Bus slave: addr_ok after addrLat cycles of request, data_ok dataLat cycles later.
  always @(negedge clk) begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    if (rst) begin
      respWait = 1'b0;
      respCnt  = 0;
    end else if (!respWait) begin
      if (mem_req) begin
        if (respCnt >= addrLat) begin
          mem_addr_ok = 1'b1;
          respWait    = 1'b1;
          respCnt     = 0;
          respAddr    = mem_addr;
          busLog.push_back('{mem_addr, mem_wr, mem_wstrb, mem_wdata});
        end else begin
          respCnt++;
        end
      end
    end else begin
      if (respCnt >= dataLat) begin
        mem_data_ok = 1'b1;
        mem_rdata   = useFixed ? fixedRdata : busWord(respAddr);
        respWait    = 1'b0;
        respCnt     = 0;
      end else begin
        respCnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic waitDone(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      cyc();
      if (!inst_stall && !data_stall) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int          base, dataFall, instFall, hold, nExp, idx;
  bit          ok, doI, doD;
  logic [31:0] iA, dA, dD, expInstR, expDataR;
  logic [3:0]  dW;

  initial begin
    repeat (2) cyc();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    rst = 1'b0;

    // Single fetch, minimum latency
    cyc();
    useFixed = 1'b1; fixedRdata = 32'h2408_0001;
    inst_en = 1'b1; inst_addr = 32'hBFC0_0000;
    cyc();
    chk("fetch_req", 32'(mem_req), 1);
    chk("fetch_addr", mem_addr, 32'h1FC0_0000);
    chk("fetch_wr", 32'(mem_wr), 0);
    cyc();
    chk("fetch_stall_c2", 32'(inst_stall), 1);
    chk("fetch_req_drop", 32'(mem_req), 0);
    cyc();
    chk("fetch_stall_c3", 32'(inst_stall), 0);
    chk("fetch_rdata", inst_rdata, 32'h2408_0001);
    inst_en = 1'b0; useFixed = 1'b0;

    // Collision, data port has priority
    cyc();
    base = busLog.size();
    inst_en = 1'b1; inst_addr = 32'h0040_0000;
    data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h8000_1000;
    dataFall = -1; instFall = -1;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (!data_stall && dataFall < 0) dataFall = c;
      if (!inst_stall && instFall < 0) instFall = c;
      if (dataFall >= 0 && instFall >= 0) break;
    end
    chk("coll_data_fall", 32'(dataFall), 3);
    chk("coll_inst_fall", 32'(instFall), 6);
    chk("coll_count", 32'(busLog.size() - base), 2);
    if (busLog.size() >= base + 2) begin
      chk("coll_first_addr", busLog[base].addr, 32'h0000_1000);
      chk("coll_second_addr", busLog[base+1].addr, 32'h0040_0000);
    end
    chk("coll_data_rdata", data_rdata, busWord(32'h0000_1000));
    chk("coll_inst_rdata", inst_rdata, busWord(32'h0040_0000));
    inst_en = 1'b0; data_en = 1'b0;

    // Partial store
    cyc();
    base = busLog.size();
    data_en = 1'b1; data_wen = 4'b0011; data_wdata = 32'hDEAD_BEEF; data_addr = 32'hA000_0004;
    cyc();
    chk("st_req", 32'(mem_req), 1);
    chk("st_wr", 32'(mem_wr), 1);
    chk("st_wstrb", 32'(mem_wstrb), 32'h3);
    chk("st_addr", mem_addr, 32'h0000_0004);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    waitDone(40, ok);
    chk("st_done", 32'(ok), 1);
    chk("st_count", 32'(busLog.size() - base), 1);
    chk("st_rdata_kept", data_rdata, busWord(32'h0000_1000));
    data_en = 1'b0; data_wen = 4'h0;

    // Address backpressure
    cyc();
    base = busLog.size(); addrLat = 5;
    inst_en = 1'b1; inst_addr = 32'h9000_0010;
    cyc();
    for (int c = 0; c < 5; c++) begin
      chk("bp_req", 32'(mem_req), 1);
      chk("bp_addr", mem_addr, 32'h1000_0010);
      chk("bp_wr", 32'(mem_wr), 0);
      chk("bp_wstrb", 32'(mem_wstrb), 0);
      cyc();
    end
    waitDone(40, ok);
    chk("bp_done", 32'(ok), 1);
    chk("bp_count", 32'(busLog.size() - base), 1);
    chk("bp_rdata", inst_rdata, busWord(32'h1000_0010));
    inst_en = 1'b0; addrLat = 0;

    // Pipeline hold after completion
    cyc();
    base = busLog.size(); useFixed = 1'b1; fixedRdata = 32'hCAFE_F00D; pipe_stall = 1'b1;
    inst_en = 1'b1; inst_addr = 32'h0000_0100;
    waitDone(40, ok);
    chk("hold_done", 32'(ok), 1);
    chk("hold_rdata0", inst_rdata, 32'hCAFE_F00D);
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("hold_rdata", inst_rdata, 32'hCAFE_F00D);
      chk("hold_stall", 32'(inst_stall), 0);
      chk("hold_noreq", 32'(mem_req), 0);
    end
    chk("hold_count", 32'(busLog.size() - base), 1);
    pipe_stall = 1'b0; inst_addr = 32'h0000_0104; fixedRdata = 32'h0BAD_F00D;
    cyc();
    chk("hold_reissue_stall", 32'(inst_stall), 1);
    cyc();
    chk("hold_reissue_req", 32'(mem_req), 1);
    chk("hold_reissue_addr", mem_addr, 32'h0000_0104);
    waitDone(40, ok);
    chk("hold_reissue_rdata", inst_rdata, 32'h0BAD_F00D);
    inst_en = 1'b0;

    // Flush while waiting for fetch data
    cyc();
    base = busLog.size(); fixedRdata = 32'h1111_1111; dataLat = 2;
    inst_en = 1'b1; inst_addr = 32'h0000_0200;
    cyc();
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_stall", 32'(inst_stall), 1);
    cyc();
    fixedRdata = 32'h2222_2222; dataLat = 0;
    cyc();
    chk("fl_rdata_kept", inst_rdata, 32'h0BAD_F00D);
    chk("fl_stall2", 32'(inst_stall), 1);
    waitDone(40, ok);
    chk("fl_done", 32'(ok), 1);
    chk("fl_count", 32'(busLog.size() - base), 2);
    if (busLog.size() >= base + 2) chk("fl_refetch_addr", busLog[base+1].addr, 32'h0000_0200);
    chk("fl_rdata_new", inst_rdata, 32'h2222_2222);
    inst_en = 1'b0; useFixed = 1'b0;

    // Reset in the middle of a store
    cyc();
    dataLat = 3;
    data_en = 1'b1; data_wen = 4'hF; data_wdata = 32'h1234_5678; data_addr = 32'h0000_0300;
    cyc();
    chk("rw_req", 32'(mem_req), 1);
    cyc();
    rst = 1'b1; data_en = 1'b0; data_wen = 4'h0;
    cyc();
    chk("rw_mem_req", 32'(mem_req), 0);
    chk("rw_mem_wr", 32'(mem_wr), 0);
    chk("rw_mem_wstrb", 32'(mem_wstrb), 0);
    chk("rw_mem_addr", mem_addr, 0);
    chk("rw_mem_wdata", mem_wdata, 0);
    chk("rw_inst_rdata", inst_rdata, 0);
    chk("rw_data_rdata", data_rdata, 0);
    cyc();
    rst = 1'b0; dataLat = 0;

    // Randomized request pairs
    expInstR = 32'h0; expDataR = 32'h0;
    for (int it = 0; it < 40; it++) begin
      cyc();
      doI = 1'($urandom_range(0, 1));
      doD = 1'($urandom_range(0, 1));
      if (!doI && !doD) doI = 1'b1;
      iA = randAddr();
      dA = randAddr();
      dW = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      dD = $urandom;
      addrLat = int'($urandom_range(0, 3));
      dataLat = int'($urandom_range(0, 3));
      hold = int'($urandom_range(0, 3));
      base = busLog.size();
      nExp = int'(doI) + int'(doD);
      if (doI) expInstR = busWord(physOf(iA));
      if (doD && dW == 4'h0) expDataR = busWord(physOf(dA));
      inst_en = doI; inst_addr = iA;
      data_en = doD; data_wen = dW; data_addr = dA; data_wdata = dD;
      pipe_stall = (hold != 0);
      waitDone(80, ok);
      chk("rnd_done", 32'(ok), 1);
      chk("rnd_count", 32'(busLog.size() - base), 32'(nExp));
      if (busLog.size() - base == nExp) begin
        idx = base;
        if (doD) begin
          chk("rnd_d_addr", busLog[idx].addr, physOf(dA));
          chk("rnd_d_wr", 32'(busLog[idx].wr), 32'(dW != 4'h0));
          chk("rnd_d_wstrb", 32'(busLog[idx].wstrb), 32'(dW));
          if (dW != 4'h0) chk("rnd_d_wdata", busLog[idx].wdata, dD);
          idx++;
        end
        if (doI) begin
          chk("rnd_i_addr", busLog[idx].addr, physOf(iA));
          chk("rnd_i_wr", 32'(busLog[idx].wr), 0);
        end
      end
      chk("rnd_inst_rdata", inst_rdata, expInstR);
      chk("rnd_data_rdata", data_rdata, expDataR);
      for (int h = 0; h < hold; h++) begin
        cyc();
        chk("rnd_hold_noreq", 32'(mem_req), 0);
        chk("rnd_hold_rdata", inst_rdata, expInstR);
      end
      pipe_stall = 1'b0; inst_en = 1'b0; data_en = 1'b0; data_wen = 4'h0;
    end

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
